// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: RV32I fetch front end with wait-state tolerant imem port,
// DEPTH-entry prefetch FIFO of {pc, instr}, branch redirect/flush and halt.
module riscv_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 4,
    parameter logic [XLEN-1:0] START_ADDR = '0
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   hlt,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    output logic                   instr_valid,
    output logic [31:0]            instr,
    output logic [XLEN-1:0]        instr_pc,
    input  logic                   instr_ready,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t          state_q;
    logic            req_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [XLEN-1:0] pc_mem_q  [DEPTH];
    logic [31:0]     ins_mem_q [DEPTH];
    logic            ack;
    logic            push;
    logic            pop;
    logic            space;
    logic            go;

    always_comb begin
        ack        = req_q & imem_ack;
        push       = (state_q == WAIT) & ack & ~redirect_valid;
        pop        = instr_valid & instr_ready & ~redirect_valid;
        count_d    = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        space      = count_d < FULL;
        go         = ~hlt & ~redirect_valid & space;
        fetch_pc_d = redirect_valid ? (redirect_pc & ~XLEN'(3)) :
                     push ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= START_ADDR;
            fetch_pc_q <= START_ADDR;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            case (state_q)
                IDLE: if (go) begin
                    state_q <= WAIT;
                    req_q   <= 1'b1;
                    addr_q  <= fetch_pc_q;
                end
                // A redirect never withdraws a live request; it is drained in DROP.
                WAIT: if (redirect_valid) begin
                    if (ack) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end else begin
                        state_q <= DROP;
                    end
                end else if (ack) begin
                    if (go) begin
                        addr_q <= fetch_pc_d;
                    end else begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                DROP: if (ack) begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    pc_mem_q[wr_ptr_q]  <= fetch_pc_q;
                    ins_mem_q[wr_ptr_q] <= imem_rdata;
                    wr_ptr_q            <= wr_ptr_q + AW'(1);
                end
                if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = count_q != '0;
    assign instr       = ins_mem_q[rd_ptr_q];
    assign instr_pc    = pc_mem_q[rd_ptr_q];
    assign fifo_count  = count_q;
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit: directed plan scenarios plus random traffic against a
// queue-based reference model of the fetch unit.
module tb_riscv_fetch_unit;
    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic        hlt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_ready = 1'b0;
    logic        imem_req, instr_valid, imem_req2, instr_valid2;
    logic [31:0] imem_addr, instr, instr_pc, imem_addr2, instr2, instr_pc2;
    logic [2:0]  fifo_count, fifo_count2;

    int n_tests = 0;
    int n_fail  = 0;

    logic        m_req, m_drop;
    logic [31:0] m_addr, m_pc;
    logic [63:0] q[$];

    riscv_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .START_ADDR(32'h0)) dut (
        .clk_in(clk_in), .rst(rst), .hlt(hlt), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .fifo_count(fifo_count));

    riscv_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .START_ADDR(32'h8000_0000)) dut2 (
        .clk_in(clk_in), .rst(rst), .hlt(hlt), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid2),
        .instr(instr2), .instr_pc(instr_pc2), .instr_ready(instr_ready),
        .fifo_count(fifo_count2));

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req  = 1'b0;
        m_drop = 1'b0;
        m_addr = 32'h0;
        m_pc   = 32'h0;
        q.delete();
    endtask

    // One clock edge of the fetch unit's contract, stated as request/queue rules.
    task automatic model_step();
        logic a;
        a = m_req && imem_ack;
        if (redirect_valid) begin
            q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            if (m_req && !a) m_drop = 1'b1;
            else begin
                m_req  = 1'b0;
                m_drop = 1'b0;
            end
        end else begin
            if (q.size() != 0 && instr_ready) void'(q.pop_front());
            if (a) begin
                if (!m_drop) begin
                    q.push_back({m_pc, imem_rdata});
                    m_pc = m_pc + 32'd4;
                end
                if (!m_drop && !hlt && q.size() < DEPTH) m_addr = m_pc;
                else m_req = 1'b0;
                m_drop = 1'b0;
            end else if (!m_req && !hlt && q.size() < DEPTH) begin
                m_req  = 1'b1;
                m_addr = m_pc;
            end
        end
    endtask

    task automatic compare();
        check("imem_req", imem_req, m_req);
        check("imem_addr", imem_addr, m_addr);
        check("instr_valid", instr_valid, q.size() != 0);
        check("fifo_count", fifo_count, q.size());
        if (q.size() != 0) begin
            check("instr", instr, q[0][31:0]);
            check("instr_pc", instr_pc, q[0][63:32]);
        end
    endtask

    task automatic tick(input logic h, input logic rv, input logic [31:0] rpc,
                        input logic ack, input logic [31:0] rd, input logic rdy);
        hlt            = h;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ack       = ack;
        imem_rdata     = rd;
        instr_ready    = rdy;
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hlt = 1'b0;
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk_in);
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_addr2", imem_addr2, 32'h8000_0000);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk_in);
        do_reset();

        // zero-wait memory, consumer always ready
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 0, 1, m_addr ^ 32'hA5A5_0000, 1);
            if (i == 0) check("first_addr", imem_addr, 32'h0);
            if (i == 1) check("first_valid_pc", {31'h0, instr_valid, instr_pc}, {31'h0, 1'b1, 32'h0});
            if (i == 2) check("second_pc", instr_pc, 32'h4);
        end

        // backpressure fills the FIFO, then drain in order
        do_reset();
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 1, $urandom, 0);
        check("full_count", fifo_count, 3'd4);
        check("full_noreq", imem_req, 1'b0);
        check("full_head_pc", instr_pc, 32'h0);
        tick(0, 0, 0, 0, 0, 1);
        check("resume_addr", {imem_req, imem_addr}, {1'b1, 32'h10});
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 0, 1);

        // redirect during a wait state drains the request into DROP
        do_reset();
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 1, 32'h0000_0103, 0, 0, 1);
        check("drop_req_held", {imem_req, fifo_count}, {1'b1, 3'd0});
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 32'hDEAD_BEEF, 1);
        check("drop_done", {imem_req, instr_valid, fifo_count}, {2'b00, 3'd0});
        tick(0, 0, 0, 0, 0, 1);
        check("redirect_addr", {imem_req, imem_addr}, {1'b1, 32'h100});

        // redirect coinciding with ack and pop at count 2
        do_reset();
        tick(0, 0, 0, 1, 32'h1111_0000, 0);
        tick(0, 0, 0, 1, 32'h1111_0001, 0);
        tick(0, 0, 0, 1, 32'h1111_0002, 0);
        check("pre_flush_count", fifo_count, 3'd2);
        tick(0, 1, 32'h0000_0200, 1, 32'h1111_0003, 1);
        check("flush_count", {imem_req, fifo_count}, {1'b0, 3'd0});
        tick(0, 0, 0, 0, 0, 1);
        check("flush_target", {imem_req, imem_addr}, {1'b1, 32'h200});

        // halt lets the outstanding request finish but issues nothing new
        do_reset();
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 1, 32'h2222_2222, 0);
        check("hlt_push", {imem_req, fifo_count}, {1'b0, 3'd1});
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 1, 0, 0);
        check("hlt_idle", {imem_req, fifo_count}, {1'b0, 3'd1});
        tick(0, 0, 0, 0, 0, 0);
        check("hlt_resume", {imem_req, imem_addr}, {1'b1, 32'h4});

        // asynchronous reset in the middle of a WAIT cycle
        do_reset();
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 32'h3333_3333, 0);
        tick(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("async_req", imem_req, 1'b0);
        check("async_count", {instr_valid, fifo_count}, {1'b0, 3'd0});
        check("async_req2", {imem_req2, fifo_count2}, {1'b0, 3'd0});
        @(negedge clk_in);
        rst = 1'b0;
        model_reset();
        tick(0, 0, 0, 0, 0, 0);
        check("post_rst_addr", {imem_req, imem_addr}, {1'b1, 32'h0});
        check("post_rst_addr2", {imem_req2, imem_addr2}, {1'b1, 32'h8000_0000});

        // random traffic: wait states, halts, redirects, backpressure
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom,
                 $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) != 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation RV32I core.
- Replaces the single-cycle combinational fetch path of the current riscv_cpu.
- Owns the fetch PC and drives a valid/ack instruction-memory port that tolerates wait states.
- Buffers fetched words with their PCs in a DEPTH-entry prefetch FIFO, and supports branch redirect with flush and halt.

Parameters:
XLEN, 32, width of PC and address paths (32 only for RV32I; kept parametric for RV64 reuse)
DEPTH, 4, prefetch FIFO entries; power of two, >= 2
START_ADDR, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0

Ports:
clk_in  input  1  core clock, rising-edge
rst  input  1  asynchronous, active-high reset
hlt  input  1  halt: no new fetch requests while high
redirect_valid  input  1  branch/jump taken; flush and refetch
redirect_pc  input  XLEN  redirect target; bits [1:0] ignored (forced 0)
imem_req  output  1  fetch request valid (registered)
imem_addr  output  XLEN  fetch address (registered, word aligned)
imem_ack  input  1  memory returns imem_rdata this cycle; sampled only while imem_req=1
imem_rdata  input  32  instruction word
instr_valid  output  1  FIFO head valid (count != 0)
instr  output  32  FIFO head instruction
instr_pc  output  XLEN  FIFO head PC
instr_ready  input  1  consumer pops head when instr_valid & instr_ready
fifo_count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, asynchronous assert):
  - imem_req=0, imem_addr=START_ADDR, fetch_pc=START_ADDR.
  - FIFO empty: instr_valid=0, fifo_count=0; instr/instr_pc=0.
  - FSM=IDLE.
- Reset mid-transaction abandons any outstanding request without waiting for ack; memory-side cleanup is the memory's responsibility.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, data to be kept.
  - DROP: request outstanding, data to be discarded.
- Space condition: space = (count_next + 1 <= DEPTH), where count_next includes this edge's push/pop.
- IDLE transitions:
  - If !hlt & !redirect_valid & space: go to WAIT, imem_req<=1, imem_addr<=fetch_pc.
  - Otherwise stay in IDLE.
- WAIT, imem_ack=0: hold imem_req=1 and imem_addr stable. The request is never withdrawn except by reset.
- WAIT, imem_ack=1 (no redirect):
  - Push {fetch_pc, imem_rdata}; fetch_pc += 4 (wraps mod 2^XLEN).
  - If !hlt & space: stay in WAIT with imem_addr <= new fetch_pc (back-to-back).
  - Otherwise go to IDLE with imem_req<=0.
- Throughput: 1 instr/cycle with zero-wait memory.
- Latency: imem_req rises at the 1st edge after rst falls. With ack in that cycle, instr_valid rises at the 2nd edge.
- Redirect (redirect_valid=1), highest priority:
  - FIFO flushed at the edge (count=0); any same-cycle pop is discarded.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - In WAIT or DROP with imem_ack=0: go to DROP (keep imem_req high, addr unchanged).
  - Otherwise (IDLE, or ack this cycle): go to IDLE; any acked data is discarded.
  - Next request issues from IDLE on the following cycle if allowed.
- DROP:
  - Hold request until imem_ack; on ack discard data, deassert imem_req, go to IDLE.
  - A further redirect in DROP only updates fetch_pc.
- Simultaneous push & pop: count unchanged, head advances. A pop is never lost when the FIFO is full.
- Full FIFO: no request is issued, so no overflow. Empty: instr_valid=0; instr_ready is ignored.
- hlt:
  - Blocks new requests only.
  - An outstanding request completes and pushes.
  - The FIFO keeps draining.
  - Redirect still applies.
- FIFO pointers: log2(DEPTH) bits, natural wrap; head outputs are read combinationally from registers.

Test Plan:
- Reset release, zero-wait memory (ack=imem_req, rdata=addr^32'hA5A5_0000), ready=1 -> imem_addr 0,4,8,... on consecutive cycles; instr_valid from 2nd edge; instr_pc increments by 4 each cycle.
- ready=0, DEPTH=4 -> exactly 4 acks; then imem_req=0 and fifo_count=4. Raise ready -> 4 pops in order (PCs 0,4,8,C) and fetch resumes at 0x10.
- Memory with 3 wait states; redirect_valid with redirect_pc=0x0000_0103 in 1st wait cycle -> FSM DROP, imem_req held until ack, data discarded, fifo_count=0; next imem_addr=0x100.
- Redirect on same cycle as ack and pop with fifo_count=2 -> count=0, acked word not pushed, next request at target.
- hlt asserted while a request is outstanding -> request completes and pushes 1 entry; no further imem_req until hlt=0, then the fetch resumes at the next sequential PC.
- rst asserted mid-WAIT (asynchronously, between edges) -> imem_req=0 and fifo_count=0 immediately; after release, first fetch at START_ADDR (run with START_ADDR=0x8000_0000 as well).
